// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM: round-robin with a bounded lock,
// and read results steered back to their issuer after the RAM read latency.
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

    state_t             state;
    logic               last;
    logic [CNT_W-1:0]   lock_cnt;
    logic               at_limit;
    logic               granted;
    logic               win;
    logic               win_lock;
    logic               other_req;
    logic               owner_match;
    logic               push_vld;
    logic [READ_LAT-1:0] rd_vld_p;
    logic [READ_LAT-1:0] rd_port_p;
    logic               unused_addr_bits;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(MAX_LOCK)) ? c : c + 1'b1;
    endfunction

    assign at_limit = (lock_cnt == CNT_W'(MAX_LOCK));

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            if (req0 && !req1) begin
                gnt0 = 1'b1;
            end else if (req1 && !req0) begin
                gnt1 = 1'b1;
            end else if (req0 && req1) begin
                case (state)
                    LOCK0: begin
                        gnt0 = !at_limit;
                        gnt1 = at_limit;
                    end
                    LOCK1: begin
                        gnt1 = !at_limit;
                        gnt0 = at_limit;
                    end
                    default: begin
                        gnt0 = last;
                        gnt1 = !last;
                    end
                endcase
            end
        end
    end

    assign granted     = gnt0 | gnt1;
    assign win         = gnt1;
    assign win_lock    = win ? lock1 : lock0;
    assign other_req   = win ? req0 : req1;
    assign owner_match = (state == LOCK0 && !win) || (state == LOCK1 && win);

    // RAM drive: with no grant, port 0 is presented and the write strobe is held low
    assign mem_address = gnt1 ? addr1[ADDR_W+1:2] : addr0[ADDR_W+1:2];
    assign mem_data    = gnt1 ? wdata1 : wdata0;
    assign mem_wren    = (gnt1 & we1) | (gnt0 & we0);

    assign unused_addr_bits = ^{addr0[31:ADDR_W+2], addr0[1:0], addr1[31:ADDR_W+2], addr1[1:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ARB;
            last     <= 1'b1;
            lock_cnt <= '0;
        end else if (!granted) begin
            state    <= ARB;
            lock_cnt <= '0;
        end else begin
            last <= win;
            if (win_lock) begin
                state <= win ? LOCK1 : LOCK0;
                if (!owner_match) begin
                    lock_cnt <= '0;
                end else if (other_req) begin
                    lock_cnt <= sat_inc(lock_cnt);
                end
            end else begin
                state    <= ARB;
                lock_cnt <= '0;
            end
        end
    end

    // Read-tag pipeline stage p0 .. p(READ_LAT-1): tail aligns with mem_q
    assign push_vld = granted & ~(win ? we1 : we0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_vld_p <= '0;
        end else begin
            rd_vld_p[0] <= push_vld;
            for (int i = 1; i < READ_LAT; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        rd_port_p[0] <= win;
        for (int i = 1; i < READ_LAT; i++) begin
            rd_port_p[i] <= rd_port_p[i-1];
        end
    end

    assign rvalid0 = reset & rd_vld_p[READ_LAT-1] & ~rd_port_p[READ_LAT-1];
    assign rvalid1 = reset & rd_vld_p[READ_LAT-1] &  rd_port_p[READ_LAT-1];
    assign rdata0  = mem_q;
    assign rdata1  = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: READ_LAT=1 instance with a RAM model, plus a READ_LAT=2 instance.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [7:0]  mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    logic        b_req0, b_req1, b_we0, b_we1, b_lock0, b_lock1;
    logic [31:0] b_addr0, b_addr1, b_wdata0, b_wdata1;
    logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1;
    logic [31:0] b_rdata0, b_rdata1;
    logic [7:0]  b_mem_address;
    logic [31:0] b_mem_data;
    logic        b_mem_wren;
    logic [31:0] b_mem_q;
    logic [31:0] b_q_a;

    logic [31:0] ram [0:255];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .READ_LAT(1), .MAX_LOCK(4)) u1 (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .READ_LAT(2), .MAX_LOCK(4)) u2 (
        .clk(clk), .reset(reset),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1), .lock0(b_lock0), .lock1(b_lock1),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
        .rdata0(b_rdata0), .rdata1(b_rdata1),
        .mem_address(b_mem_address), .mem_data(b_mem_data), .mem_wren(b_mem_wren), .mem_q(b_mem_q)
    );

    always #5 clk = ~clk;

    // RAM models: one-cycle read for u1, two-cycle read for u2 (read-only)
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q   <= ram[mem_address];
        b_q_a   <= ram[b_mem_address];
        b_mem_q <= b_q_a;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 | i;
        reset = 1'b0;
        {req0, req1, we0, we1, lock0, lock1} = '0;
        addr0 = 32'h20; addr1 = 32'h44; wdata0 = '0; wdata1 = '0;
        {b_req0, b_req1, b_we0, b_we1, b_lock0, b_lock1} = '0;
        b_addr0 = '0; b_addr1 = '0; b_wdata0 = 32'h5555_0000; b_wdata1 = 32'h1234;
        tick();
        tick();

        // Reset holds everything off even with both requesting and a write pending
        req0 = 1; req1 = 1; we0 = 1;
        #1;
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        chk1("rst_wren", mem_wren, 1'b0);
        chk1("rst_rvalid0", rvalid0, 1'b0);
        chk1("rst_rvalid1", rvalid1, 1'b0);
        tick();
        reset = 1; we0 = 0;

        // Ping-pong reads; first grant after reset goes to port 0
        for (int k = 0; k < 6; k++) begin
            #1;
            chk1($sformatf("pp_gnt0_%0d", k), gnt0, (k % 2) == 0);
            chk1($sformatf("pp_gnt1_%0d", k), gnt1, (k % 2) == 1);
            chk32($sformatf("pp_addr_%0d", k), {24'h0, mem_address}, (k % 2) == 0 ? 32'h08 : 32'h11);
            chk1($sformatf("pp_wren_%0d", k), mem_wren, 1'b0);
            if (k > 0) begin
                chk1($sformatf("pp_rv0_%0d", k), rvalid0, (k % 2) == 1);
                chk1($sformatf("pp_rv1_%0d", k), rvalid1, (k % 2) == 0);
                if ((k % 2) == 1) chk32($sformatf("pp_rd0_%0d", k), rdata0, 32'hA500_0008);
                else              chk32($sformatf("pp_rd1_%0d", k), rdata1, 32'hA500_0011);
            end
            tick();
        end
        req0 = 0; req1 = 0;
        #1;
        chk1("pp_rv1_last", rvalid1, 1'b1);
        chk1("pp_rv0_last", rvalid0, 1'b0);
        chk32("pp_rd1_last", rdata1, 32'hA500_0011);
        chk32("idle_addr", {24'h0, mem_address}, 32'h08);
        chk1("idle_wren", mem_wren, 1'b0);
        tick();

        // Store then load at byte address 0x10 (word 4)
        req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF;
        #1;
        chk1("st_gnt0", gnt0, 1'b1);
        chk32("st_addr", {24'h0, mem_address}, 32'h04);
        chk1("st_wren", mem_wren, 1'b1);
        chk32("st_data", mem_data, 32'hDEAD_BEEF);
        tick();
        we0 = 0;
        #1;
        chk1("ld_gnt0", gnt0, 1'b1);
        chk1("ld_wren", mem_wren, 1'b0);
        chk1("st_no_rvalid", rvalid0, 1'b0);
        tick();
        req0 = 0;
        #1;
        chk1("ld_rvalid0", rvalid0, 1'b1);
        chk32("ld_rdata0", rdata0, 32'hDEAD_BEEF);
        chk1("ld_rvalid1", rvalid1, 1'b0);
        tick();
        chk1("ld_rvalid0_once", rvalid0, 1'b0);

        // Lock bound: port 1 locked, both requesting; last winner was port 0
        req0 = 1; req1 = 1; lock1 = 1;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk1($sformatf("lk_gnt1_%0d", k), gnt1, k != 5);
            chk1($sformatf("lk_gnt0_%0d", k), gnt0, k == 5);
            tick();
        end
        req0 = 0; req1 = 0; lock1 = 0;
        tick();

        // Reset mid-read: a locked port-1 read is dropped and the lock released
        req1 = 1; lock1 = 1; addr1 = 32'h44;
        #1;
        chk1("mr_gnt1", gnt1, 1'b1);
        tick();
        reset = 0; req1 = 0; lock1 = 0;
        #1;
        chk1("mr_rv1_in_rst", rvalid1, 1'b0);
        tick();
        reset = 1;
        #1;
        chk1("mr_rv1_after", rvalid1, 1'b0);
        req0 = 1; req1 = 1; addr0 = 32'h20;
        #1;
        chk1("mr_tie_gnt0", gnt0, 1'b1);
        chk1("mr_tie_gnt1", gnt1, 1'b0);
        tick();
        req0 = 0; req1 = 0;
        #1;
        chk1("mr_rv0", rvalid0, 1'b1);
        chk32("mr_rd0", rdata0, 32'hA500_0008);
        chk1("mr_rv1", rvalid1, 1'b0);
        tick();

        // Alignment and two-cycle read latency on the second instance
        b_req1 = 1; b_addr1 = 32'h3FF;
        #1;
        chk1("al_gnt1", b_gnt1, 1'b1);
        chk1("al_gnt0", b_gnt0, 1'b0);
        chk32("al_addr", {24'h0, b_mem_address}, 32'hFF);
        chk1("al_wren", b_mem_wren, 1'b0);
        chk32("al_data", b_mem_data, 32'h1234);
        tick();
        b_req1 = 0;
        #1;
        chk1("al_rv1_early", b_rvalid1, 1'b0);
        tick();
        chk1("al_rv1", b_rvalid1, 1'b1);
        chk1("al_rv0", b_rvalid0, 1'b0);
        chk32("al_rd1", b_rdata1, 32'hA500_00FF);
        chk32("al_rd0_bus", b_rdata0, 32'hA500_00FF);
        tick();
        chk1("al_rv1_once", b_rvalid1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
